// File: rtl/store_write_buffer_pkg.sv
// Shared definitions for the store write buffer: default parameters and drain FSM states.
package store_write_buffer_pkg;

    localparam int unsigned DEF_DWIDTH    = 16;
    localparam int unsigned DEF_AWIDTH    = 16;
    localparam int unsigned DEF_DEPTH     = 4;
    localparam int unsigned DEF_WR_CYCLES = 4;

    typedef enum logic {
        StIdle,
        StWrite
    } drain_state_e;

endpackage

// File: rtl/store_write_buffer_fifo.sv
// In-order {addr, data} FIFO with wrapping pointers and a youngest-match forwarding compare.
module store_write_buffer_fifo
    import store_write_buffer_pkg::*;
#(
    parameter int unsigned DWIDTH = DEF_DWIDTH,
    parameter int unsigned AWIDTH = DEF_AWIDTH,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [AWIDTH-1:0]        push_addr,
    input  logic [DWIDTH-1:0]        push_data,
    input  logic                     pop,
    output logic [AWIDTH-1:0]        head_addr,
    output logic [DWIDTH-1:0]        head_data,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [AWIDTH-1:0]        ld_addr,
    output logic                     fwd_hit,
    output logic [DWIDTH-1:0]        fwd_data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AWIDTH-1:0] addr_q [DEPTH];
    logic [DWIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              push_ok, pop_ok;
    logic [PW-1:0]     fwd_idx;

    assign push_ok = push && (count_q != CW'(DEPTH));
    assign pop_ok  = pop && (count_q != '0);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_q[wr_ptr_q] <= push_addr;
            data_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign count     = count_q;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[fwd_idx] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: FIFO of pending stores drained to memory by a two-state write FSM.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int unsigned DWIDTH    = DEF_DWIDTH,
    parameter int unsigned AWIDTH    = DEF_AWIDTH,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned WR_CYCLES = DEF_WR_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [AWIDTH-1:0]        st_addr,
    input  logic [DWIDTH-1:0]        st_data,
    output logic                     st_ready,
    input  logic                     mem_grant,
    output logic                     drain_req,
    output logic                     mem_wr_en,
    output logic [AWIDTH-1:0]        mem_addr,
    output logic [DWIDTH-1:0]        mem_data,
    input  logic [AWIDTH-1:0]        ld_addr,
    output logic                     fwd_hit,
    output logic [DWIDTH-1:0]        fwd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int unsigned CW        = $clog2(DEPTH) + 1;
    localparam int unsigned CNTW      = $clog2(WR_CYCLES) + 1;
    localparam int unsigned LAST_CNT  = (WR_CYCLES > 1) ? WR_CYCLES - 2 : 0;
    localparam bit          SINGLE_WR = (WR_CYCLES == 1);

    drain_state_e      state_q;
    logic [CNTW-1:0]   cnt_q;
    logic              busy_q;
    logic              issue, pop;
    logic [AWIDTH-1:0] head_addr;
    logic [DWIDTH-1:0] head_data;

    store_write_buffer_fifo #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (st_valid && st_ready),
        .push_addr (st_addr),
        .push_data (st_data),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (count),
        .ld_addr   (ld_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
    );

    assign st_ready  = (count != CW'(DEPTH));
    assign drain_req = (count != '0);
    assign issue     = (state_q == StIdle) && drain_req && mem_grant;
    // Single-cycle writes retire at issue; otherwise the head leaves on the last WRITE cycle.
    assign pop       = (issue && SINGLE_WR) || ((state_q == StWrite) && (cnt_q == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (issue && !SINGLE_WR) begin
                        state_q <= StWrite;
                        cnt_q   <= CNTW'(LAST_CNT);
                        busy_q  <= 1'b1;
                    end
                end
                StWrite: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign mem_wr_en = issue;
    assign mem_addr  = issue ? head_addr : '0;
    assign mem_data  = issue ? head_data : '0;

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed and random stimulus for store_write_buffer, checked against a queue-based model.
module tb_store_write_buffer;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int WRC   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          mem_grant;
    logic          drain_req;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] ld_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [2:0]    count;
    logic          busy;

    store_write_buffer #(
        .DWIDTH    (DW),
        .AWIDTH    (AW),
        .DEPTH     (DEPTH),
        .WR_CYCLES (WRC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .mem_grant (mem_grant),
        .drain_req (drain_req),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .ld_addr   (ld_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .count     (count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t q[$];
    int   wleft;  // WRITE cycles still to run, counting the current one; 0 = idle
    int   total = 0;
    int   bad   = 0;
    int   writes;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Check all outputs against the model mid-cycle, then advance the model over the edge.
    task automatic cycle();
        logic          issue, hit, pop, push;
        logic [DW-1:0] fd;
        @(negedge clk);
        issue = (wleft == 0) && (q.size() != 0) && mem_grant;
        hit   = 1'b0;
        fd    = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a == ld_addr) begin
                hit = 1'b1;
                fd  = q[i].d;
                break;
            end
        end
        check("st_ready", st_ready, q.size() != DEPTH);
        check("drain_req", drain_req, q.size() != 0);
        check("count", count, q.size());
        check("busy", busy, wleft > 0);
        check("mem_wr_en", mem_wr_en, issue);
        check("mem_addr", mem_addr, issue ? q[0].a : '0);
        check("mem_data", mem_data, issue ? q[0].d : '0);
        check("fwd_hit", fwd_hit, hit);
        check("fwd_data", fwd_data, fd);
        if (issue) writes++;
        @(posedge clk);
        push = st_valid && (q.size() != DEPTH);
        pop  = (wleft == 1) || (issue && WRC == 1);
        if (wleft > 0) wleft--;
        else if (issue) wleft = WRC - 1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back('{a: st_addr, d: st_data});
        #1;
    endtask

    task automatic drive_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
    endtask

    initial begin
        rst       = 1'b1;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        mem_grant = 1'b0;
        ld_addr   = '0;
        wleft     = 0;
        writes    = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_st_ready", st_ready, 1);
        check("rst_count", count, 0);
        check("rst_drain_req", drain_req, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_wr_en", mem_wr_en, 0);
        rst = 1'b0;

        // Single store, then watch its write occupancy.
        drive_store(16'h0040, 16'hBEEF);
        mem_grant = 1'b1;
        cycle();
        st_valid = 1'b0;
        check("single_wr_en", mem_wr_en, 1);
        check("single_addr", mem_addr, 16'h0040);
        check("single_data", mem_data, 16'hBEEF);
        cycle();
        check("single_busy1", busy, 1);
        check("single_wr_en_off", mem_wr_en, 0);
        cycle();
        cycle();
        check("single_busy3", busy, 1);
        check("single_count_hold", count, 1);
        cycle();
        check("single_count_done", count, 0);
        check("single_busy_done", busy, 0);

        // Fill to full with memory held off; the fifth store must bounce.
        mem_grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_store(AW'(16'h0100 + i), DW'(16'hA000 + i));
            cycle();
        end
        st_valid = 1'b0;
        check("full_count", count, 4);
        check("full_st_ready", st_ready, 0);
        mem_grant = 1'b1;
        writes    = 0;
        for (int i = 0; i < 16; i++) cycle();
        check("full_drain_writes", writes, 4);
        check("full_drain_empty", count, 0);

        // Forwarding: youngest of two same-address stores wins.
        mem_grant = 1'b0;
        drive_store(16'h0010, 16'h1111);
        cycle();
        drive_store(16'h0010, 16'h2222);
        ld_addr = 16'h0010;
        cycle();
        st_valid = 1'b0;
        check("fwd_young_hit", fwd_hit, 1);
        check("fwd_young_data", fwd_data, 16'h2222);
        ld_addr = 16'h0012;
        #1;
        check("fwd_miss_hit", fwd_hit, 0);
        check("fwd_miss_data", fwd_data, 0);
        cycle();

        // Full with a pop in the same cycle: push refused, accepted one cycle later.
        drive_store(16'h0020, 16'h3333);
        cycle();
        drive_store(16'h0030, 16'h4444);
        cycle();
        st_valid  = 1'b0;
        mem_grant = 1'b1;
        for (int i = 0; i < 10 && wleft != 1; i++) cycle();
        check("wrap_reached_last", wleft, 1);
        drive_store(16'h0050, 16'h5555);
        cycle();
        check("wrap_refused_count", count, 3);
        cycle();
        st_valid = 1'b0;
        check("wrap_accepted_count", count, 4);
        for (int i = 0; i < 20; i++) cycle();

        // Reset on the second WRITE cycle drops the in-flight store.
        drive_store(16'h0060, 16'h6666);
        ld_addr = 16'h0060;
        cycle();
        st_valid = 1'b0;
        for (int i = 0; i < 10 && wleft != 2; i++) cycle();
        check("rstw_reached", wleft, 2);
        rst = 1'b1;
        #1;
        check("rstw_wr_en", mem_wr_en, 0);
        check("rstw_busy", busy, 0);
        check("rstw_count", count, 0);
        check("rstw_st_ready", st_ready, 1);
        check("rstw_drain_req", drain_req, 0);
        check("rstw_fwd_hit", fwd_hit, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        wleft  = 0;
        writes = 0;
        for (int i = 0; i < 8; i++) cycle();
        check("rstw_no_writes", writes, 0);

        // Grant toggling during a write must not launch another.
        drive_store(16'h0070, 16'h7777);
        cycle();
        drive_store(16'h0080, 16'h8888);
        cycle();
        st_valid = 1'b0;
        writes   = 0;
        for (int i = 0; i < 6; i++) begin
            mem_grant = i[0];
            cycle();
        end
        check("toggle_one_write", writes, 1);
        mem_grant = 1'b1;
        for (int i = 0; i < 10; i++) cycle();

        // Random traffic over a small address set to exercise forwarding.
        for (int i = 0; i < 400; i++) begin
            st_valid  = 1'($urandom_range(0, 1));
            st_addr   = AW'($urandom_range(0, 3));
            st_data   = DW'($urandom);
            mem_grant = 1'($urandom_range(0, 1));
            ld_addr   = AW'($urandom_range(0, 3));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
